// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared types and width helpers for the Goertzel bin scheduler
package goertzel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_PWR_ISSUE,
        ST_PWR_DRAIN
    } sched_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int BIN_W_DEF = clog2_w(4);
    localparam int CNT_W_DEF = clog2_w(520);

endpackage

// File: rtl/goertzel_tag_delay.sv
// rtl/goertzel_tag_delay.sv - fixed-depth {valid,tag} delay line with async clear
// Ports:
//   clock, reset_n        clock and asynchronous active-low clear
//   in_valid, in_tag      entry launched this cycle
//   out_valid, out_tag    entry launched exactly DEPTH cycles earlier
module goertzel_tag_delay #(
    parameter int DEPTH = 40,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_tag,
    output logic         out_valid,
    output logic [W-1:0] out_tag
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     tag [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];

endmodule

// File: rtl/goertzel_bin_scheduler.sv
// rtl/goertzel_bin_scheduler.sv - sequences one shared Goertzel datapath across NUM_BINS bins
// Ports:
//   clock, reset_n                  system clock, asynchronous active-low reset
//   run, sample_valid, clr_overrun  enable, new-sample pulse, overrun clear
//   dp_issue/dp_bin/dp_first        datapath launch, bin index, first-sample qualifier
//   wb_en/wb_bin                    delayed state write-back for a bin
//   pwr_start/pwr_bin               power evaluation launch
//   pwr_done/pwr_done_bin           power result valid for a bin
//   block_done, busy, sample_idx, overrun  status
module goertzel_bin_scheduler
    import goertzel_pkg::*;
#(
    parameter  int NUM_BINS  = 4,
    parameter  int BLOCK_LEN = 520,
    parameter  int PIPE_LAT  = 40,
    parameter  int PWR_LAT   = 40,
    localparam int BIN_W     = clog2_w(NUM_BINS),
    localparam int CNT_W     = clog2_w(BLOCK_LEN)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             sample_valid,
    input  logic             clr_overrun,
    output logic             dp_issue,
    output logic [BIN_W-1:0] dp_bin,
    output logic             dp_first,
    output logic             wb_en,
    output logic [BIN_W-1:0] wb_bin,
    output logic             pwr_start,
    output logic [BIN_W-1:0] pwr_bin,
    output logic             pwr_done,
    output logic [BIN_W-1:0] pwr_done_bin,
    output logic             block_done,
    output logic             busy,
    output logic [CNT_W-1:0] sample_idx,
    output logic             overrun
);

    localparam int               OUT_W    = clog2_w(NUM_BINS + 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    sched_state_t     state, state_nxt;
    logic [BIN_W-1:0] bin_cnt, bin_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic [OUT_W-1:0] outstanding, out_nxt;
    logic             dp_issue_nxt, dp_first_nxt, pwr_start_nxt, block_done_nxt;
    logic [BIN_W-1:0] dp_bin_nxt, pwr_bin_nxt;

    // Ops in flight through the datapath; DRAIN looks at the post-update value
    // so the FSM leaves DRAIN on the same cycle the last write-back appears.
    assign out_nxt = outstanding + OUT_W'(dp_issue) - OUT_W'(wb_en);

    always_comb begin
        state_nxt      = state;
        bin_nxt        = bin_cnt;
        idx_nxt        = sample_idx;
        dp_issue_nxt   = 1'b0;
        dp_bin_nxt     = '0;
        dp_first_nxt   = 1'b0;
        pwr_start_nxt  = 1'b0;
        pwr_bin_nxt    = '0;
        block_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_valid && run) begin
                    state_nxt    = ST_ISSUE;
                    bin_nxt      = '0;
                    dp_issue_nxt = 1'b1;
                    dp_first_nxt = (sample_idx == '0);
                end else if (!run && sample_idx != '0) begin
                    idx_nxt = '0;
                end
            end
            ST_ISSUE: begin
                if (bin_cnt == LAST_BIN) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    bin_nxt      = bin_cnt + 1'b1;
                    dp_issue_nxt = 1'b1;
                    dp_bin_nxt   = bin_cnt + 1'b1;
                    dp_first_nxt = dp_first;
                end
            end
            ST_DRAIN: begin
                if (out_nxt == '0) begin
                    if (sample_idx == LAST_IDX) begin
                        state_nxt     = ST_PWR_ISSUE;
                        bin_nxt       = '0;
                        pwr_start_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = sample_idx + 1'b1;
                    end
                end
            end
            ST_PWR_ISSUE: begin
                if (bin_cnt == LAST_BIN) begin
                    state_nxt = ST_PWR_DRAIN;
                end else begin
                    bin_nxt       = bin_cnt + 1'b1;
                    pwr_start_nxt = 1'b1;
                    pwr_bin_nxt   = bin_cnt + 1'b1;
                end
            end
            ST_PWR_DRAIN: begin
                // Power ops complete in issue order, so the last bin is the last result.
                if (pwr_done && pwr_done_bin == LAST_BIN) begin
                    state_nxt      = ST_IDLE;
                    block_done_nxt = 1'b1;
                    idx_nxt        = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bin_cnt     <= '0;
            sample_idx  <= '0;
            outstanding <= '0;
            dp_issue    <= 1'b0;
            dp_bin      <= '0;
            dp_first    <= 1'b0;
            pwr_start   <= 1'b0;
            pwr_bin     <= '0;
            block_done  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            bin_cnt     <= bin_nxt;
            sample_idx  <= idx_nxt;
            outstanding <= out_nxt;
            dp_issue    <= dp_issue_nxt;
            dp_bin      <= dp_bin_nxt;
            dp_first    <= dp_first_nxt;
            pwr_start   <= pwr_start_nxt;
            pwr_bin     <= pwr_bin_nxt;
            block_done  <= block_done_nxt;
            busy        <= (state_nxt != ST_IDLE);
            // A new drop event beats a simultaneous clear.
            if (sample_valid && state != ST_IDLE) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    goertzel_tag_delay #(.DEPTH(PIPE_LAT), .W(BIN_W)) u_wb_delay (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (dp_issue),
        .in_tag    (dp_bin),
        .out_valid (wb_en),
        .out_tag   (wb_bin)
    );

    goertzel_tag_delay #(.DEPTH(PWR_LAT), .W(BIN_W)) u_pwr_delay (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (pwr_start),
        .in_tag    (pwr_bin),
        .out_valid (pwr_done),
        .out_tag   (pwr_done_bin)
    );

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// tb/tb_goertzel_bin_scheduler.sv - scoreboard bench for goertzel_bin_scheduler
module tb_goertzel_bin_scheduler;

    localparam int NB = 4;
    localparam int BL = 8;
    localparam int PL = 40;
    localparam int WL = 40;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       sample_valid = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       dp_issue, dp_first, wb_en, pwr_start, pwr_done, block_done, busy, overrun;
    logic [1:0] dp_bin, wb_bin, pwr_bin, pwr_done_bin;
    logic [2:0] sample_idx;

    goertzel_bin_scheduler #(
        .NUM_BINS(NB), .BLOCK_LEN(BL), .PIPE_LAT(PL), .PWR_LAT(WL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .sample_valid(sample_valid),
        .clr_overrun(clr_overrun), .dp_issue(dp_issue), .dp_bin(dp_bin), .dp_first(dp_first),
        .wb_en(wb_en), .wb_bin(wb_bin), .pwr_start(pwr_start), .pwr_bin(pwr_bin),
        .pwr_done(pwr_done), .pwr_done_bin(pwr_done_bin), .block_done(block_done),
        .busy(busy), .sample_idx(sample_idx), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard queues: each entry packs the expected cycle with bin / flags.
    longint q_dp[$];
    longint q_wb[$];
    longint q_ps[$];
    longint q_pd[$];
    longint q_bd[$];

    int m_start = -1;
    int m_idle_at = 0;
    int m_idx = 0;
    int m_ovr = 0;
    int outst = 0;
    int max_outst = 0;
    int wb_cnt = 0;
    int bd_cnt = 0;
    int ps_cnt = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            check("busy", busy, (cyc > m_start && cyc < m_idle_at));
            if (dp_issue) begin
                if (q_dp.size() == 0) check("dp_issue_extra", cyc, -1);
                else check("dp_issue", longint'(cyc) * 8 + longint'(dp_bin) * 2 + longint'(dp_first), q_dp.pop_front());
            end
            if (wb_en) begin
                wb_cnt++;
                if (q_wb.size() == 0) check("wb_extra", cyc, -1);
                else check("wb_en", longint'(cyc) * 4 + longint'(wb_bin), q_wb.pop_front());
            end
            if (pwr_start) begin
                ps_cnt++;
                if (q_ps.size() == 0) check("pwr_start_extra", cyc, -1);
                else check("pwr_start", longint'(cyc) * 4 + longint'(pwr_bin), q_ps.pop_front());
            end
            if (pwr_done) begin
                if (q_pd.size() == 0) check("pwr_done_extra", cyc, -1);
                else check("pwr_done", longint'(cyc) * 4 + longint'(pwr_done_bin), q_pd.pop_front());
            end
            if (block_done) begin
                bd_cnt++;
                if (q_bd.size() == 0) check("block_done_extra", cyc, -1);
                else check("block_done", cyc, q_bd.pop_front());
            end
            outst = outst + int'(dp_issue) - int'(wb_en);
            if (outst > max_outst) max_outst = outst;
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One-cycle sample pulse; the model decides accept / overrun / silent drop.
    task automatic send();
        int t;
        int p0;
        @(posedge clock);
        #1;
        sample_valid = 1'b1;
        t = cyc;
        if (t > m_start && t < m_idle_at) begin
            m_ovr = 1;
        end else if (run) begin
            m_start = t;
            for (int k = 0; k < NB; k++) begin
                q_dp.push_back(longint'(t + 1 + k) * 8 + k * 2 + ((m_idx == 0) ? 1 : 0));
                q_wb.push_back(longint'(t + 1 + k + PL) * 4 + k);
            end
            m_idle_at = t + NB + PL + 1;
            if (m_idx == BL - 1) begin
                p0 = m_idle_at;
                for (int k = 0; k < NB; k++) begin
                    q_ps.push_back(longint'(p0 + k) * 4 + k);
                    q_pd.push_back(longint'(p0 + k + WL) * 4 + k);
                end
                m_idle_at = p0 + NB - 1 + WL + 1;
                q_bd.push_back(m_idle_at);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_when_idle();
        while (cyc + 1 < m_idle_at) @(posedge clock);
        send();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_sample_idx"}, sample_idx, m_idx);
        check({tag, "_overrun"}, overrun, m_ovr);
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {dp_issue, dp_bin, dp_first, wb_en, wb_bin, pwr_start, pwr_bin,
                    pwr_done, pwr_done_bin, block_done, busy, sample_idx, overrun}, 0);
    endtask

    initial begin
        int bd0;
        gap(3);
        check_outs_zero("reset_outputs");
        reset_n = 1'b1;
        run = 1'b1;
        gap(2);

        // single sample, then the rest of the block
        send();
        gap(60);
        check_state("t1");
        for (int s = 1; s < BL; s++) begin
            send();
            gap(98);
        end
        check("t2_wb_count", wb_cnt, NB * BL);
        check("t2_pwr_count", ps_cnt, NB);
        check("t2_block_done", bd_cnt, 1);
        check_state("t2");

        // overrun, then clear
        send();
        gap(19);
        send();
        gap(80);
        check_state("t3_set");
        @(posedge clock);
        #1;
        clr_overrun = 1'b1;
        @(posedge clock);
        #1;
        clr_overrun = 1'b0;
        m_ovr = 0;
        check_state("t3_clr");

        // abort after sample 3, silent drop while stopped, restart at first sample
        send();
        gap(60);
        send();
        gap(60);
        check_state("t4_before");
        run = 1'b0;
        gap(5);
        m_idx = 0;
        check_state("t4_abort");
        send();
        gap(5);
        check_state("t4_drop");
        run = 1'b1;
        send();
        gap(60);
        check_state("t4_restart");

        // reset during DRAIN
        send();
        gap(20);
        reset_n = 1'b0;
        #1;
        check_outs_zero("t5_in_reset");
        q_dp.delete();
        q_wb.delete();
        m_idx = 0;
        m_ovr = 0;
        m_start = -1;
        m_idle_at = 0;
        outst = 0;
        gap(2);
        check_outs_zero("t5_reset_held");
        reset_n = 1'b1;
        gap(60);
        check_state("t5_after");
        send();
        gap(60);

        // abort the partial block, then two full blocks at minimum spacing
        run = 1'b0;
        gap(3);
        m_idx = 0;
        run = 1'b1;
        bd0 = bd_cnt;
        max_outst = 0;
        for (int s = 0; s < 2 * BL; s++) begin
            send_when_idle();
        end
        gap(100);
        check("t6_block_done", bd_cnt - bd0, 2);
        check("t6_max_outstanding", max_outst <= NB, 1);
        check_state("t6");

        check("queues_empty", q_dp.size() + q_wb.size() + q_ps.size() + q_pd.size() + q_bd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
